// File: rtl/axi4_mst_bridge_if.sv
// Bridge-facing bundle: simple request/response side plus the AXI4 master channel structs.
interface axi4_mst_bridge_if #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 64,
    parameter int ID_BITS   = 4,
    parameter int USER_BITS = 1
);
    localparam int DATA_BYTES = DATA_BITS / 8;

    typedef struct packed {
        logic                 aw_ready;
        logic                 w_ready;
        logic                 b_valid;
        logic [1:0]           b_resp;
        logic [ID_BITS-1:0]   b_id;
        logic [USER_BITS-1:0] b_user;
        logic                 ar_ready;
        logic                 r_valid;
        logic [1:0]           r_resp;
        logic [DATA_BITS-1:0] r_data;
        logic                 r_last;
        logic [ID_BITS-1:0]   r_id;
        logic [USER_BITS-1:0] r_user;
    } axi4_master_in_type;

    typedef struct packed {
        logic                  aw_valid;
        logic [ADDR_BITS-1:0]  aw_addr;
        logic [7:0]            aw_len;
        logic [2:0]            aw_size;
        logic [1:0]            aw_burst;
        logic [ID_BITS-1:0]    aw_id;
        logic [USER_BITS-1:0]  aw_user;
        logic                  w_valid;
        logic [DATA_BITS-1:0]  w_data;
        logic [DATA_BYTES-1:0] w_strb;
        logic                  w_last;
        logic [USER_BITS-1:0]  w_user;
        logic                  b_ready;
        logic                  ar_valid;
        logic [ADDR_BITS-1:0]  ar_addr;
        logic [7:0]            ar_len;
        logic [2:0]            ar_size;
        logic [1:0]            ar_burst;
        logic [ID_BITS-1:0]    ar_id;
        logic [USER_BITS-1:0]  ar_user;
        logic                  r_ready;
    } axi4_master_out_type;

    axi4_master_in_type    i_msti;
    axi4_master_out_type   o_msto;

    logic                  i_req_valid;
    logic                  o_req_ready;
    logic                  i_req_write;
    logic [ADDR_BITS-1:0]  i_req_addr;
    logic [7:0]            i_req_len;
    logic                  i_wvalid;
    logic [DATA_BITS-1:0]  i_wdata;
    logic [DATA_BYTES-1:0] i_wstrb;
    logic                  o_wready;
    logic                  o_resp_valid;
    logic [DATA_BITS-1:0]  o_resp_rdata;
    logic                  o_resp_err;
    logic                  o_resp_last;
    logic                  i_resp_ready;

    // master: the bridge itself; slave: the requester plus the AXI fabric around it
    modport master (
        input  i_msti, i_req_valid, i_req_write, i_req_addr, i_req_len,
               i_wvalid, i_wdata, i_wstrb, i_resp_ready,
        output o_msto, o_req_ready, o_wready, o_resp_valid, o_resp_rdata,
               o_resp_err, o_resp_last
    );

    modport slave (
        output i_msti, i_req_valid, i_req_write, i_req_addr, i_req_len,
               i_wvalid, i_wdata, i_wstrb, i_resp_ready,
        input  o_msto, o_req_ready, o_wready, o_resp_valid, o_resp_rdata,
               o_resp_err, o_resp_last
    );
endinterface

// File: rtl/axi4_mst_bridge.sv
// Request/response to AXI4 master bridge, one INCR burst outstanding at a time.
// Optional sticky error-address capture under `define AXI4_MST_BRIDGE_ERRCAPT_EN.
module axi4_mst_bridge #(
    parameter int CFG_SYSBUS_ADDR_BITS = 32,
    parameter int CFG_SYSBUS_DATA_BITS = 64,
    parameter int ID_BITS              = 4,
    parameter int USER_BITS            = 1,
    parameter int req_id               = 0,
    parameter int user_bits            = 0
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
`ifdef AXI4_MST_BRIDGE_ERRCAPT_EN
    input  logic                            i_err_clr,
    output logic                            o_err_valid,
    output logic [CFG_SYSBUS_ADDR_BITS-1:0] o_err_addr,
`endif
    axi4_mst_bridge_if.master               bus
);
    localparam int DATA_BYTES = CFG_SYSBUS_DATA_BITS / 8;
    localparam int SIZE_LOG2  = $clog2(DATA_BYTES);

    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, ERR} state_t;

    state_t                          state, state_n;
    logic [CFG_SYSBUS_ADDR_BITS-1:0] addr_q;
    logic [7:0]                      len_q;
    logic [7:0]                      beat_cnt, beat_cnt_n;
    logic                            req_fire;
    logic [12:0]                     span;
    logic                            cross_4k;
    logic                            unused_msti;

    assign req_fire = bus.i_req_valid & bus.o_req_ready;
    // end offset of the burst within its 4 KB page; exactly 4096 still fits
    assign span     = 13'(bus.i_req_addr[11:0]) + ((13'(bus.i_req_len) + 13'd1) << SIZE_LOG2);
    assign cross_4k = span > 13'd4096;

    assign unused_msti = ^{bus.i_msti.b_id, bus.i_msti.b_user, bus.i_msti.r_id,
                           bus.i_msti.r_user, bus.i_msti.b_resp[0], bus.i_msti.r_resp[0]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            addr_q   <= '0;
            len_q    <= '0;
        end else begin
            state    <= state_n;
            beat_cnt <= beat_cnt_n;
            if (req_fire) begin
                addr_q <= bus.i_req_addr;
                len_q  <= bus.i_req_len;
            end
        end
    end

    always_comb begin
        state_n          = state;
        beat_cnt_n       = beat_cnt;
        bus.o_msto       = '0;
        bus.o_req_ready  = 1'b0;
        bus.o_wready     = 1'b0;
        bus.o_resp_valid = 1'b0;
        bus.o_resp_rdata = '0;
        bus.o_resp_err   = 1'b0;
        bus.o_resp_last  = 1'b0;
        case (state)
            IDLE: begin
                bus.o_req_ready = ~i_rst;
                if (req_fire) begin
                    beat_cnt_n = '0;
                    if (cross_4k)             state_n = ERR;
                    else if (bus.i_req_write) state_n = AW;
                    else                      state_n = AR;
                end
            end
            AR: begin
                bus.o_msto.ar_valid = 1'b1;
                bus.o_msto.ar_addr  = addr_q;
                bus.o_msto.ar_len   = len_q;
                bus.o_msto.ar_size  = 3'(SIZE_LOG2);
                bus.o_msto.ar_burst = 2'b01;
                bus.o_msto.ar_id    = ID_BITS'(req_id);
                bus.o_msto.ar_user  = USER_BITS'(user_bits);
                if (bus.i_msti.ar_ready) state_n = R;
            end
            R: begin
                // completion is keyed on r_last alone so a miscounting slave cannot wedge us
                bus.o_msto.r_ready = bus.i_resp_ready;
                bus.o_resp_valid   = bus.i_msti.r_valid;
                bus.o_resp_rdata   = bus.i_msti.r_data;
                bus.o_resp_last    = bus.i_msti.r_last;
                bus.o_resp_err     = bus.i_msti.r_resp[1];
                if (bus.i_msti.r_valid & bus.i_resp_ready & bus.i_msti.r_last) state_n = IDLE;
            end
            AW: begin
                bus.o_msto.aw_valid = 1'b1;
                bus.o_msto.aw_addr  = addr_q;
                bus.o_msto.aw_len   = len_q;
                bus.o_msto.aw_size  = 3'(SIZE_LOG2);
                bus.o_msto.aw_burst = 2'b01;
                bus.o_msto.aw_id    = ID_BITS'(req_id);
                bus.o_msto.aw_user  = USER_BITS'(user_bits);
                if (bus.i_msti.aw_ready) state_n = W;
            end
            W: begin
                bus.o_msto.w_valid = bus.i_wvalid;
                bus.o_msto.w_data  = bus.i_wdata;
                bus.o_msto.w_strb  = bus.i_wstrb;
                bus.o_msto.w_last  = (beat_cnt == len_q);
                bus.o_msto.w_user  = USER_BITS'(user_bits);
                bus.o_wready       = bus.i_msti.w_ready;
                if (bus.i_wvalid & bus.i_msti.w_ready) begin
                    beat_cnt_n = beat_cnt + 8'd1;
                    if (beat_cnt == len_q) state_n = B;
                end
            end
            B: begin
                bus.o_msto.b_ready = bus.i_resp_ready;
                bus.o_resp_valid   = bus.i_msti.b_valid;
                bus.o_resp_err     = bus.i_msti.b_resp[1];
                bus.o_resp_last    = 1'b1;
                if (bus.i_msti.b_valid & bus.i_resp_ready) state_n = IDLE;
            end
            ERR: begin
                bus.o_resp_valid = 1'b1;
                bus.o_resp_err   = 1'b1;
                bus.o_resp_last  = 1'b1;
                if (bus.i_resp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef AXI4_MST_BRIDGE_ERRCAPT_EN
    logic resp_err_hs;
    assign resp_err_hs = bus.o_resp_valid & bus.o_resp_err & bus.i_resp_ready;

    // first error sticks; a clear in the same cycle as a new error yields to the error
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_err_valid <= 1'b0;
            o_err_addr  <= '0;
        end else if (resp_err_hs && (!o_err_valid || i_err_clr)) begin
            o_err_valid <= 1'b1;
            o_err_addr  <= addr_q;
        end else if (i_err_clr) begin
            o_err_valid <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_axi4_mst_bridge.sv
// Directed bench for axi4_mst_bridge: reads, writes, 4 KB rejection, backpressure, mid-burst reset.
module tb_axi4_mst_bridge;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    axi4_mst_bridge_if bus ();

`ifdef AXI4_MST_BRIDGE_ERRCAPT_EN
    logic        err_clr;
    logic        err_valid;
    logic [31:0] err_addr;
`endif

    axi4_mst_bridge #(.req_id(5), .user_bits(1)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
`ifdef AXI4_MST_BRIDGE_ERRCAPT_EN
        .i_err_clr   (err_clr),
        .o_err_valid (err_valid),
        .o_err_addr  (err_addr),
`endif
        .bus         (bus.master)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic wr, input logic [31:0] a, input logic [7:0] l);
        bus.i_req_valid = 1'b1;
        bus.i_req_write = wr;
        bus.i_req_addr  = a;
        bus.i_req_len   = l;
        #1;
        chk("req_ready_idle", 64'(bus.o_req_ready), 64'd1);
        step();
        bus.i_req_valid = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        bus.i_msti      = '0;
        bus.i_req_valid = 1'b0;
        bus.i_req_write = 1'b0;
        bus.i_req_addr  = '0;
        bus.i_req_len   = '0;
        bus.i_wvalid    = 1'b0;
        bus.i_wdata     = '0;
        bus.i_wstrb     = '0;
        bus.i_resp_ready = 1'b0;
`ifdef AXI4_MST_BRIDGE_ERRCAPT_EN
        err_clr = 1'b0;
`endif
        #12;
        chk("rst_req_ready", 64'(bus.o_req_ready), 64'd0);
        chk("rst_ar_valid", 64'(bus.o_msto.ar_valid), 64'd0);
        chk("rst_resp_valid", 64'(bus.o_resp_valid), 64'd0);
        chk("rst_wready", 64'(bus.o_wready), 64'd0);
`ifdef AXI4_MST_BRIDGE_ERRCAPT_EN
        chk("rst_err_valid", 64'(err_valid), 64'd0);
`endif
        rst = 1'b0;
        step();

        // 4-beat read, everything ready
        req(1'b0, 32'h8000_1000, 8'd3);
        #1;
        chk("ar_valid", 64'(bus.o_msto.ar_valid), 64'd1);
        chk("ar_len", 64'(bus.o_msto.ar_len), 64'd3);
        chk("ar_burst", 64'(bus.o_msto.ar_burst), 64'd1);
        chk("ar_size", 64'(bus.o_msto.ar_size), 64'd3);
        chk("ar_addr", 64'(bus.o_msto.ar_addr), 64'h8000_1000);
        chk("ar_id", 64'(bus.o_msto.ar_id), 64'd5);
        chk("req_ready_busy", 64'(bus.o_req_ready), 64'd0);
        bus.i_msti.ar_ready = 1'b1;
        step();
        bus.i_msti.ar_ready = 1'b0;
        #1;
        chk("ar_valid_drop", 64'(bus.o_msto.ar_valid), 64'd0);
        bus.i_resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.i_msti.r_valid = 1'b1;
            bus.i_msti.r_data  = 64'h11 * 64'(i + 1);
            bus.i_msti.r_last  = (i == 3);
            #1;
            chk("rd_valid", 64'(bus.o_resp_valid), 64'd1);
            chk("rd_data", bus.o_resp_rdata, 64'h11 * 64'(i + 1));
            chk("rd_last", 64'(bus.o_resp_last), (i == 3) ? 64'd1 : 64'd0);
            chk("r_ready", 64'(bus.o_msto.r_ready), 64'd1);
            step();
        end
        bus.i_msti.r_valid = 1'b0;
        bus.i_msti.r_last  = 1'b0;
        #1;
        chk("rd_done_req_ready", 64'(bus.o_req_ready), 64'd1);

        // 2-beat write, w_ready toggling
        req(1'b1, 32'h8000_2000, 8'd1);
        #1;
        chk("aw_valid", 64'(bus.o_msto.aw_valid), 64'd1);
        chk("aw_len", 64'(bus.o_msto.aw_len), 64'd1);
        chk("aw_addr", 64'(bus.o_msto.aw_addr), 64'h8000_2000);
        bus.i_msti.aw_ready = 1'b1;
        step();
        bus.i_msti.aw_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.i_wvalid       = 1'b1;
            bus.i_wdata        = (k >= 2) ? 64'hBB : 64'hAA;
            bus.i_wstrb        = 8'hFF;
            bus.i_msti.w_ready = (k % 2 == 1);
            #1;
            chk("w_valid", 64'(bus.o_msto.w_valid), 64'd1);
            chk("w_data", bus.o_msto.w_data, (k >= 2) ? 64'hBB : 64'hAA);
            chk("w_strb", 64'(bus.o_msto.w_strb), 64'hFF);
            chk("w_last", 64'(bus.o_msto.w_last), (k >= 2) ? 64'd1 : 64'd0);
            chk("wready", 64'(bus.o_wready), (k % 2 == 1) ? 64'd1 : 64'd0);
            step();
        end
        bus.i_wvalid       = 1'b0;
        bus.i_msti.w_ready = 1'b0;
        bus.i_msti.b_valid = 1'b1;
        bus.i_msti.b_resp  = 2'b00;
        #1;
        chk("b_w_valid_off", 64'(bus.o_msto.w_valid), 64'd0);
        chk("b_resp_valid", 64'(bus.o_resp_valid), 64'd1);
        chk("b_resp_err", 64'(bus.o_resp_err), 64'd0);
        chk("b_resp_last", 64'(bus.o_resp_last), 64'd1);
        chk("b_rdata_zero", bus.o_resp_rdata, 64'd0);
        chk("b_ready", 64'(bus.o_msto.b_ready), 64'd1);
        step();
        bus.i_msti.b_valid = 1'b0;
        #1;
        chk("wr_done_resp_valid", 64'(bus.o_resp_valid), 64'd0);
        chk("wr_done_req_ready", 64'(bus.o_req_ready), 64'd1);

        // 4 KB crossing: 0xFF8 + 2*8 = 0x1008
        req(1'b0, 32'h8000_0FF8, 8'd1);
        #1;
        chk("x4k_no_ar", 64'(bus.o_msto.ar_valid), 64'd0);
        chk("x4k_resp_valid", 64'(bus.o_resp_valid), 64'd1);
        chk("x4k_resp_err", 64'(bus.o_resp_err), 64'd1);
        chk("x4k_resp_last", 64'(bus.o_resp_last), 64'd1);
        step();
        chk("x4k_req_ready", 64'(bus.o_req_ready), 64'd1);
        chk("x4k_no_ar_after", 64'(bus.o_msto.ar_valid), 64'd0);
`ifdef AXI4_MST_BRIDGE_ERRCAPT_EN
        chk("cap_x4k_valid", 64'(err_valid), 64'd1);
        chk("cap_x4k_addr", 64'(err_addr), 64'h8000_0FF8);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("cap_clr", 64'(err_valid), 64'd0);
`endif

        // exactly filling the page (0xFF0 + 16 = 0x1000) is legal
        req(1'b0, 32'h8000_0FF0, 8'd1);
        #1;
        chk("edge4k_ar_valid", 64'(bus.o_msto.ar_valid), 64'd1);
        bus.i_msti.ar_ready = 1'b1;
        step();
        bus.i_msti.ar_ready = 1'b0;
        bus.i_msti.r_valid  = 1'b1;
        bus.i_msti.r_data   = 64'h77;
        bus.i_msti.r_last   = 1'b1;
        #1;
        chk("edge4k_rdata", bus.o_resp_rdata, 64'h77);
        chk("edge4k_err", 64'(bus.o_resp_err), 64'd0);
        step();
        bus.i_msti.r_valid = 1'b0;
        bus.i_msti.r_last  = 1'b0;

        // 1-beat write answered with SLVERR
        req(1'b1, 32'h8000_3000, 8'd0);
        bus.i_msti.aw_ready = 1'b1;
        step();
        bus.i_msti.aw_ready = 1'b0;
        bus.i_wvalid        = 1'b1;
        bus.i_wdata         = 64'hCC;
        bus.i_msti.w_ready  = 1'b1;
        #1;
        chk("w1_last", 64'(bus.o_msto.w_last), 64'd1);
        step();
        bus.i_wvalid       = 1'b0;
        bus.i_msti.w_ready = 1'b0;
        bus.i_msti.b_valid = 1'b1;
        bus.i_msti.b_resp  = 2'b10;
        #1;
        chk("slverr_err", 64'(bus.o_resp_err), 64'd1);
        chk("slverr_last", 64'(bus.o_resp_last), 64'd1);
        step();
        bus.i_msti.b_valid = 1'b0;
        bus.i_msti.b_resp  = 2'b00;
`ifdef AXI4_MST_BRIDGE_ERRCAPT_EN
        chk("cap_slverr_valid", 64'(err_valid), 64'd1);
        chk("cap_slverr_addr", 64'(err_addr), 64'h8000_3000);
        req(1'b0, 32'h8000_0FF8, 8'd1);
        step();
        chk("cap_sticky_addr", 64'(err_addr), 64'h8000_3000);
        req(1'b0, 32'h8000_4FF8, 8'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("cap_clr_vs_err_valid", 64'(err_valid), 64'd1);
        chk("cap_clr_vs_err_addr", 64'(err_addr), 64'h8000_4FF8);
`endif

        // read with the requester stalling for 5 cycles
        req(1'b0, 32'h8000_5000, 8'd1);
        bus.i_msti.ar_ready = 1'b1;
        step();
        bus.i_msti.ar_ready = 1'b0;
        bus.i_resp_ready    = 1'b0;
        bus.i_msti.r_valid  = 1'b1;
        bus.i_msti.r_data   = 64'h55;
        bus.i_msti.r_last   = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("stall_r_ready", 64'(bus.o_msto.r_ready), 64'd0);
            chk("stall_resp_valid", 64'(bus.o_resp_valid), 64'd1);
            chk("stall_rdata", bus.o_resp_rdata, 64'h55);
            step();
        end
        bus.i_resp_ready = 1'b1;
        #1;
        chk("stall_release_r_ready", 64'(bus.o_msto.r_ready), 64'd1);
        chk("stall_release_rdata", bus.o_resp_rdata, 64'h55);
        chk("stall_release_last", 64'(bus.o_resp_last), 64'd0);
        step();
        bus.i_msti.r_data = 64'h66;
        bus.i_msti.r_last = 1'b1;
        #1;
        chk("stall_beat2_rdata", bus.o_resp_rdata, 64'h66);
        chk("stall_beat2_last", 64'(bus.o_resp_last), 64'd1);
        step();
        bus.i_msti.r_valid = 1'b0;
        bus.i_msti.r_last  = 1'b0;
        #1;
        chk("stall_done_req_ready", 64'(bus.o_req_ready), 64'd1);

        // reset in W after 1 of 3 beats
        req(1'b1, 32'h8000_6000, 8'd2);
        bus.i_msti.aw_ready = 1'b1;
        step();
        bus.i_msti.aw_ready = 1'b0;
        bus.i_wvalid        = 1'b1;
        bus.i_wdata         = 64'h01;
        bus.i_msti.w_ready  = 1'b1;
        step();
        bus.i_wdata = 64'h02;
        #1;
        chk("mid_w_cnt", 64'(dut.beat_cnt), 64'd1);
        chk("mid_w_valid", 64'(bus.o_msto.w_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_w_valid", 64'(bus.o_msto.w_valid), 64'd0);
        chk("mid_rst_wready", 64'(bus.o_wready), 64'd0);
        chk("mid_rst_req_ready", 64'(bus.o_req_ready), 64'd0);
        chk("mid_rst_resp_valid", 64'(bus.o_resp_valid), 64'd0);
        chk("mid_rst_aw_valid", 64'(bus.o_msto.aw_valid), 64'd0);
        bus.i_wvalid       = 1'b0;
        bus.i_msti.w_ready = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", 64'(bus.o_req_ready), 64'd1);
        chk("post_rst_cnt", 64'(dut.beat_cnt), 64'd0);
        chk("post_rst_state", 64'(dut.state), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
